// File: rtl/alarm_bank_pkg.sv
// Shared types, codes and BCD helpers for the alarm bank.
package alarm_bank_pkg;

    localparam int unsigned MAX_CH = 8;
    localparam logic [2:0] RING_ID_SNOOZE = 3'd7;

    typedef enum logic [1:0] {
        FLD_NONE = 2'b00,
        FLD_MIN  = 2'b01,
        FLD_HOUR = 2'b10,
        FLD_ARM  = 2'b11
    } set_field_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RINGING = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] minute;
    } hhmm_t;

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        logic [6:0] tens;
        tens = v / 7'd10;
        return {4'(tens), 4'(v - tens * 7'd10)};
    endfunction

endpackage

// File: rtl/alarm_bank_if.sv
// Control/status bundle between the time base, the alarm bank and its consumers.
interface alarm_bank_if;
    logic       tick_1hz;
    logic [7:0] cur_hour;
    logic [7:0] cur_minute;
    logic [7:0] cur_second;
    logic [2:0] sel_alarm;
    logic [1:0] set_field;
    logic       set_inc;
    logic       stop;
    logic       snooze;
    logic [7:0] disp_hour;
    logic [7:0] disp_minute;
    logic [7:0] armed;
    logic       ring;
    logic [2:0] ring_id;

    modport master (
        output tick_1hz, cur_hour, cur_minute, cur_second,
        output sel_alarm, set_field, set_inc, stop, snooze,
        input  disp_hour, disp_minute, armed, ring, ring_id
    );

    modport slave (
        input  tick_1hz, cur_hour, cur_minute, cur_second,
        input  sel_alarm, set_field, set_inc, stop, snooze,
        output disp_hour, disp_minute, armed, ring, ring_id
    );
endinterface

// File: rtl/alarm_bank_bcd_wrap_inc.sv
// Combinational two-digit BCD increment that wraps MAX_BCD back to 00.
module alarm_bank_bcd_wrap_inc #(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic [7:0] val_i,
    output logic [7:0] val_o
);

    always_comb begin
        if (val_i == MAX_BCD) begin
            val_o = 8'h00;
        end else if (val_i[3:0] == 4'd9) begin
            val_o = {val_i[7:4] + 4'd1, 4'd0};
        end else begin
            val_o = {val_i[7:4], val_i[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel BCD hh:mm alarm unit with bounded ring, stop and one pending snooze.
module alarm_bank
    import alarm_bank_pkg::*;
#(
    parameter int unsigned NUM_ALARMS   = 4,
    parameter int unsigned RING_SECONDS = 60,
    parameter int unsigned SNOOZE_MIN   = 5
) (
    input  logic        clk,
    input  logic        cr,
    alarm_bank_if.slave bus
);

    localparam logic [7:0] RING_LOAD = 8'(RING_SECONDS);

    logic [7:0] hr_q [MAX_CH];
    logic [7:0] hr_d [MAX_CH];
    logic [7:0] mn_q [MAX_CH];
    logic [7:0] mn_d [MAX_CH];
    logic [MAX_CH-1:0] armed_q, armed_d;

    state_e     state_q;
    logic       ring_q;
    logic [2:0] ring_id_q;
    logic [7:0] cnt_q;
    logic       pend_q;
    hhmm_t      snz_q, trig_q;

    logic       sel_ok;
    logic [7:0] mn_inc, hr_inc;
    logic       top_of_min, chan_hit, snz_hit;
    logic [2:0] chan_id;
    hhmm_t      cur_t, snz_next;
    logic [6:0] mn_sum, mn_new, hr_bin, hr_new;
    logic       carry;

    assign sel_ok = 32'(bus.sel_alarm) < NUM_ALARMS;
    assign cur_t  = {bus.cur_hour, bus.cur_minute};

    alarm_bank_bcd_wrap_inc #(.MAX_BCD(8'h59)) u_min_inc (
        .val_i (mn_q[bus.sel_alarm]),
        .val_o (mn_inc)
    );

    alarm_bank_bcd_wrap_inc #(.MAX_BCD(8'h23)) u_hour_inc (
        .val_i (hr_q[bus.sel_alarm]),
        .val_o (hr_inc)
    );

    // Push-button edit of the selected channel; out-of-range selects are ignored.
    always_comb begin
        hr_d    = hr_q;
        mn_d    = mn_q;
        armed_d = armed_q;
        if (bus.set_inc && sel_ok) begin
            case (set_field_e'(bus.set_field))
                FLD_MIN:  mn_d[bus.sel_alarm] = mn_inc;
                FLD_HOUR: hr_d[bus.sel_alarm] = hr_inc;
                FLD_ARM:  armed_d[bus.sel_alarm] = ~armed_q[bus.sel_alarm];
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cr) begin
            for (int unsigned i = 0; i < MAX_CH; i++) begin
                hr_q[i] <= 8'h00;
                mn_q[i] <= 8'h00;
            end
            armed_q <= '0;
        end else begin
            hr_q    <= hr_d;
            mn_q    <= mn_d;
            armed_q <= armed_d;
        end
    end

    // Lowest-index armed channel matching the running time wins.
    always_comb begin
        top_of_min = bus.tick_1hz && (bus.cur_second == 8'h00);
        chan_hit   = 1'b0;
        chan_id    = 3'd0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (top_of_min && !chan_hit && (i < NUM_ALARMS) && armed_q[i] &&
                (hr_q[i] == bus.cur_hour) && (mn_q[i] == bus.cur_minute)) begin
                chan_hit = 1'b1;
                chan_id  = 3'(i);
            end
        end
        snz_hit = top_of_min && pend_q && (snz_q == cur_t);
    end

    // Snooze target: trigger time plus SNOOZE_MIN, carrying minutes into a 24 h wrapping hour.
    always_comb begin
        mn_sum   = bcd_to_bin(trig_q.minute) + 7'(SNOOZE_MIN);
        carry    = mn_sum >= 7'd60;
        mn_new   = carry ? mn_sum - 7'd60 : mn_sum;
        hr_bin   = bcd_to_bin(trig_q.hour);
        hr_new   = !carry ? hr_bin : ((hr_bin == 7'd23) ? 7'd0 : hr_bin + 7'd1);
        snz_next = {bin_to_bcd(hr_new), bin_to_bcd(mn_new)};
    end

    always_ff @(posedge clk) begin
        if (cr) begin
            state_q   <= ST_IDLE;
            ring_q    <= 1'b0;
            ring_id_q <= 3'd0;
            cnt_q     <= 8'd0;
            pend_q    <= 1'b0;
            snz_q     <= '0;
            trig_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.stop) pend_q <= 1'b0;
                    if (chan_hit) begin
                        state_q   <= ST_RINGING;
                        ring_q    <= 1'b1;
                        ring_id_q <= chan_id;
                        cnt_q     <= RING_LOAD;
                        trig_q    <= cur_t;
                    end else if (snz_hit && !bus.stop) begin
                        state_q   <= ST_RINGING;
                        ring_q    <= 1'b1;
                        ring_id_q <= RING_ID_SNOOZE;
                        cnt_q     <= RING_LOAD;
                        trig_q    <= cur_t;
                        pend_q    <= 1'b0;
                    end
                end
                ST_RINGING: begin
                    if (bus.stop) begin
                        state_q <= ST_IDLE;
                        ring_q  <= 1'b0;
                        pend_q  <= 1'b0;
                    end else if (bus.snooze) begin
                        state_q <= ST_IDLE;
                        ring_q  <= 1'b0;
                        pend_q  <= 1'b1;
                        snz_q   <= snz_next;
                    end else if (bus.tick_1hz) begin
                        if (cnt_q <= 8'd1) begin
                            state_q <= ST_IDLE;
                            ring_q  <= 1'b0;
                            cnt_q   <= 8'd0;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.disp_hour   = hr_q[bus.sel_alarm];
    assign bus.disp_minute = mn_q[bus.sel_alarm];
    assign bus.armed       = 8'(armed_q);
    assign bus.ring        = ring_q;
    assign bus.ring_id     = ring_id_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: set-path vector table plus ring/stop/snooze/reset sequences.
module tb_alarm_bank;

    logic clk;
    logic cr;
    int   total;
    int   bad;

    alarm_bank_if bus ();

    alarm_bank #(
        .NUM_ALARMS   (4),
        .RING_SECONDS (60),
        .SNOOZE_MIN   (5)
    ) dut (
        .clk (clk),
        .cr  (cr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic [1:0] fld;
        logic       inc;
        logic [7:0] e_hr;
        logic [7:0] e_mn;
        logic [7:0] e_arm;
    } vec_t;

    vec_t vecs [9];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic inc_n(input logic [2:0] sel, input logic [1:0] fld, input int n);
        for (int k = 0; k < n; k++) begin
            bus.sel_alarm = sel;
            bus.set_field = fld;
            bus.set_inc   = 1'b1;
            cyc();
        end
        bus.set_inc = 1'b0;
    endtask

    task automatic tick_at(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus.cur_hour   = h;
        bus.cur_minute = m;
        bus.cur_second = s;
        bus.tick_1hz   = 1'b1;
        cyc();
        bus.tick_1hz   = 1'b0;
    endtask

    task automatic pulse(input logic do_stop, input logic do_snooze);
        bus.stop   = do_stop;
        bus.snooze = do_snooze;
        cyc();
        bus.stop   = 1'b0;
        bus.snooze = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cr = 1'b1;
        bus.tick_1hz = 1'b0;
        bus.cur_hour = 8'h00;
        bus.cur_minute = 8'h00;
        bus.cur_second = 8'h01;
        bus.sel_alarm = 3'd0;
        bus.set_field = 2'b00;
        bus.set_inc = 1'b0;
        bus.stop = 1'b0;
        bus.snooze = 1'b0;

        vecs[0] = '{3'd0, 2'b00, 1'b1, 8'h07, 8'h30, 8'h01};
        vecs[1] = '{3'd0, 2'b01, 1'b0, 8'h07, 8'h30, 8'h01};
        vecs[2] = '{3'd5, 2'b10, 1'b1, 8'h00, 8'h00, 8'h01};
        vecs[3] = '{3'd5, 2'b11, 1'b1, 8'h00, 8'h00, 8'h01};
        vecs[4] = '{3'd3, 2'b11, 1'b1, 8'h00, 8'h00, 8'h09};
        vecs[5] = '{3'd3, 2'b11, 1'b1, 8'h00, 8'h00, 8'h01};
        vecs[6] = '{3'd1, 2'b10, 1'b1, 8'h01, 8'h00, 8'h01};
        vecs[7] = '{3'd1, 2'b01, 1'b1, 8'h01, 8'h01, 8'h01};
        vecs[8] = '{3'd0, 2'b00, 1'b0, 8'h07, 8'h30, 8'h01};

        cyc();
        cyc();
        cr = 1'b0;
        check("reset_ring", 8'(bus.ring), 8'h00);
        check("reset_ring_id", 8'(bus.ring_id), 8'h00);
        check("reset_armed", bus.armed, 8'h00);
        check("reset_disp_hr", bus.disp_hour, 8'h00);
        check("reset_disp_mn", bus.disp_minute, 8'h00);

        // Alarm 0 to 07:30, armed
        inc_n(3'd0, 2'b10, 7);
        inc_n(3'd0, 2'b01, 30);
        inc_n(3'd0, 2'b11, 1);
        check("set0_hr", bus.disp_hour, 8'h07);
        check("set0_mn", bus.disp_minute, 8'h30);
        check("set0_armed", bus.armed, 8'h01);

        for (int v = 0; v < 9; v++) begin
            bus.sel_alarm = vecs[v].sel;
            bus.set_field = vecs[v].fld;
            bus.set_inc   = vecs[v].inc;
            cyc();
            bus.set_inc   = 1'b0;
            check($sformatf("vec%0d_hr", v), bus.disp_hour, vecs[v].e_hr);
            check($sformatf("vec%0d_mn", v), bus.disp_minute, vecs[v].e_mn);
            check($sformatf("vec%0d_arm", v), bus.armed, vecs[v].e_arm);
        end

        // Minute and hour wrap on alarm 1 (currently 01:01)
        inc_n(3'd1, 2'b01, 58);
        check("min59", bus.disp_minute, 8'h59);
        inc_n(3'd1, 2'b01, 1);
        check("minwrap_mn", bus.disp_minute, 8'h00);
        check("minwrap_hr", bus.disp_hour, 8'h01);
        inc_n(3'd1, 2'b10, 22);
        check("hr23", bus.disp_hour, 8'h23);
        inc_n(3'd1, 2'b10, 1);
        check("hrwrap", bus.disp_hour, 8'h00);

        // Alarm 0 rings at 07:30:00 for exactly 60 ticks
        tick_at(8'h07, 8'h29, 8'h59);
        check("pre_ring", 8'(bus.ring), 8'h00);
        tick_at(8'h07, 8'h30, 8'h00);
        check("ring0_on", 8'(bus.ring), 8'h01);
        check("ring0_id", 8'(bus.ring_id), 8'h00);
        for (int i = 1; i <= 60; i++) begin
            tick_at(8'h07, (i == 60) ? 8'h31 : 8'h30, (i == 60) ? 8'h00 : 8'({i[3:0] == 4'd0 ? 4'd0 : 4'd0}) + 8'(((i / 10) << 4) | (i % 10)));
            if (i == 59) check("ring_t59", 8'(bus.ring), 8'h01);
            if (i == 60) check("ring_t60", 8'(bus.ring), 8'h00);
        end
        tick_at(8'h07, 8'h31, 8'h01);
        check("no_retrigger", 8'(bus.ring), 8'h00);

        // Alarms 1 and 2 both at 06:00: lowest index wins, stop silences
        inc_n(3'd1, 2'b10, 6);
        inc_n(3'd2, 2'b10, 6);
        inc_n(3'd1, 2'b11, 1);
        inc_n(3'd2, 2'b11, 1);
        check("armed_012", bus.armed, 8'h07);
        tick_at(8'h06, 8'h00, 8'h00);
        check("dual_ring", 8'(bus.ring), 8'h01);
        check("dual_id", 8'(bus.ring_id), 8'h01);
        pulse(1'b1, 1'b0);
        check("stop_ring", 8'(bus.ring), 8'h00);
        tick_at(8'h06, 8'h00, 8'h01);
        check("alarm2_dropped", 8'(bus.ring), 8'h00);

        // Alarm 3 at 23:58, snooze across midnight
        inc_n(3'd3, 2'b10, 23);
        inc_n(3'd3, 2'b01, 58);
        inc_n(3'd3, 2'b11, 1);
        check("armed_all", bus.armed, 8'h0F);
        tick_at(8'h23, 8'h58, 8'h00);
        check("ring3_on", 8'(bus.ring), 8'h01);
        check("ring3_id", 8'(bus.ring_id), 8'h03);
        inc_n(3'd3, 2'b11, 1);
        check("disarm_keeps_ring", 8'(bus.ring), 8'h01);
        check("disarm_armed", bus.armed, 8'h07);
        inc_n(3'd3, 2'b11, 1);
        pulse(1'b0, 1'b1);
        check("snooze_silence", 8'(bus.ring), 8'h00);
        tick_at(8'h00, 8'h02, 8'h00);
        check("snooze_early", 8'(bus.ring), 8'h00);
        tick_at(8'h00, 8'h03, 8'h00);
        check("snooze_ring", 8'(bus.ring), 8'h01);
        check("snooze_id", 8'(bus.ring_id), 8'h07);
        pulse(1'b1, 1'b0);
        check("snooze_stop", 8'(bus.ring), 8'h00);

        // stop and snooze together: stop wins, no later snooze ring
        tick_at(8'h23, 8'h58, 8'h00);
        check("ring3_again", 8'(bus.ring), 8'h01);
        pulse(1'b1, 1'b1);
        check("stop_snooze_off", 8'(bus.ring), 8'h00);
        tick_at(8'h00, 8'h03, 8'h00);
        check("no_snooze_ring", 8'(bus.ring), 8'h00);

        // Reset while ringing
        tick_at(8'h07, 8'h30, 8'h00);
        check("ring_before_cr", 8'(bus.ring), 8'h01);
        cr = 1'b1;
        cyc();
        cr = 1'b0;
        check("cr_ring", 8'(bus.ring), 8'h00);
        check("cr_ring_id", 8'(bus.ring_id), 8'h00);
        check("cr_armed", bus.armed, 8'h00);
        for (int s = 0; s < 4; s++) begin
            bus.sel_alarm = 3'(s);
            #1;
            check($sformatf("cr_hr%0d", s), bus.disp_hour, 8'h00);
            check($sformatf("cr_mn%0d", s), bus.disp_minute, 8'h00);
        end
        tick_at(8'h00, 8'h00, 8'h00);
        check("unarmed_match", 8'(bus.ring), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
